// File: rtl/ball_loss_detector.sv
// Ball loss detector and respawn sequencer.
// It sits upstream of the lives counter. When the ball drops past the bottom
// edge, it emits one Bottom_Hit pulse. It then holds the ball, waits a number
// of frames, requests a respawn and waits for a fresh serve press. If the
// lives counter reports game over, it parks in GAMEOVER until restart.
module ball_loss_detector #(
   parameter int               Y_W            = 10,
   parameter logic [Y_W-1:0]   SCREEN_BOTTOM  = 10'd479,
   parameter logic [Y_W-1:0]   BALL_SIZE      = 10'd8,
   parameter logic [7:0]       RESPAWN_FRAMES = 8'd60
) (
   input  logic           iCLK,
   input  logic           iRST,
   input  logic           iFrame_Tick,
   input  logic [Y_W-1:0] iBall_Y,
   input  logic           iBall_VY_Down,
   input  logic           iServe,
   input  logic           iGameOver,
   input  logic           iRestart,
   output logic           oBottom_Hit,
   output logic           oBall_Hold,
   output logic           oRespawn,
   output logic [2:0]     oState
);

   typedef enum logic [2:0] {
      PLAY     = 3'd0,
      LOST     = 3'd1,
      WAIT     = 3'd2,
      SERVE    = 3'd3,
      GAMEOVER = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       bottomHit_q, bottomHit_d;
   logic       respawn_q, respawn_d;
   logic       hold_q, hold_d;
   logic       serveSync1_q, serveSync2_q, serveDly_q;
   logic       restartPrev_q;

   logic [Y_W:0] ballBottom;
   logic         lossNow;
   logic         serveEdge;
   logic [7:0]   countInc;

   // The ball bottom is one bit wider than the coordinate, so a ball near the
   // top of the coordinate range cannot wrap around and hide a loss.
   assign ballBottom = {1'b0, iBall_Y} + {1'b0, BALL_SIZE};
   assign lossNow    = (ballBottom > {1'b0, SCREEN_BOTTOM}) && iBall_VY_Down;
   assign serveEdge  = serveSync2_q & ~serveDly_q;
   assign countInc   = count_q + 8'd1;

   // The serve button is asynchronous, so it goes through two synchroniser
   // flops and then a delay flop used for rising-edge detection. This chain
   // runs in every state. As a result, a button already held when SERVE is
   // entered produces no edge.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         serveSync1_q  <= 1'b0;
         serveSync2_q  <= 1'b0;
         serveDly_q    <= 1'b0;
         restartPrev_q <= 1'b0;
      end else begin
         serveSync1_q  <= iServe;
         serveSync2_q  <= serveSync1_q;
         serveDly_q    <= serveSync2_q;
         restartPrev_q <= iRestart;
      end
   end

   // This block holds the state register, the frame counter and the
   // registered outputs.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q     <= SERVE;
         count_q     <= 8'd0;
         bottomHit_q <= 1'b0;
         respawn_q   <= 1'b0;
         hold_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         bottomHit_q <= bottomHit_d;
         respawn_q   <= respawn_d;
         hold_q      <= hold_d;
      end
   end

   // Next-state logic. Restart overrides everything, including a loss on the
   // same cycle. A held restart raises the respawn request only on its first
   // cycle. The output values are derived from the chosen next state, so the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      respawn_d   = 1'b0;
      bottomHit_d = 1'b0;
      hold_d      = 1'b1;

      if (iRestart) begin
         state_d   = SERVE;
         count_d   = 8'd0;
         respawn_d = ~restartPrev_q;
      end else begin
         case (state_q)
            PLAY: begin
               if (iFrame_Tick && lossNow) begin
                  state_d = LOST;
               end
            end
            LOST: begin
               state_d = WAIT;
               count_d = 8'd0;
            end
            WAIT: begin
               if (iFrame_Tick) begin
                  count_d = countInc;
                  if (countInc == RESPAWN_FRAMES) begin
                     respawn_d = 1'b1;
                     state_d   = iGameOver ? GAMEOVER : SERVE;
                  end
               end
            end
            SERVE: begin
               if (serveEdge) begin
                  state_d = PLAY;
               end
            end
            GAMEOVER: begin
               state_d = GAMEOVER;
            end
            default: begin
               state_d = SERVE;
            end
         endcase
      end

      bottomHit_d = (state_d == LOST);
      hold_d      = (state_d != PLAY);
   end

   assign oBottom_Hit = bottomHit_q;
   assign oRespawn    = respawn_q;
   assign oBall_Hold  = hold_q;
   assign oState      = state_q;

endmodule

// File: tb/tb_ball_loss_detector.sv
// Directed testbench for ball_loss_detector with hand-computed expectations.
module tb_ball_loss_detector;

   logic       iCLK;
   logic       iRST;
   logic       iFrame_Tick;
   logic [9:0] iBall_Y;
   logic       iBall_VY_Down;
   logic       iServe;
   logic       iGameOver;
   logic       iRestart;
   logic       oBottom_Hit;
   logic       oBall_Hold;
   logic       oRespawn;
   logic [2:0] oState;

   int total = 0;
   int bad   = 0;

   localparam logic [2:0] S_PLAY = 3'd0;
   localparam logic [2:0] S_LOST = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SERVE = 3'd3;
   localparam logic [2:0] S_GAMEOVER = 3'd4;

   ball_loss_detector dut (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .iFrame_Tick   (iFrame_Tick),
      .iBall_Y       (iBall_Y),
      .iBall_VY_Down (iBall_VY_Down),
      .iServe        (iServe),
      .iGameOver     (iGameOver),
      .iRestart      (iRestart),
      .oBottom_Hit   (oBottom_Hit),
      .oBall_Hold    (oBall_Hold),
      .oRespawn      (oRespawn),
      .oState        (oState)
   );

   // Free-running 100 MHz clock.
   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock edge. Inputs change and outputs are sampled 1 ns later.
   task automatic applyStimulus();
      @(posedge iCLK);
      #1;
   endtask

   task automatic frameTicks(input int n);
      for (int i = 0; i < n; i++) begin
         iFrame_Tick = 1'b1;
         applyStimulus();
         iFrame_Tick = 1'b0;
         applyStimulus();
      end
   endtask

   // Serve press from a released button: PLAY shows after the third edge.
   task automatic pressServe();
      iServe = 1'b1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      iServe = 1'b0;
   endtask

   // A qualifying loss tick, followed by the LOST cycle, lands in WAIT.
   task automatic loseBall();
      iBall_Y       = 10'd472;
      iBall_VY_Down = 1'b1;
      iFrame_Tick   = 1'b1;
      applyStimulus();
      iFrame_Tick   = 1'b0;
      applyStimulus();
   endtask

   initial begin
      iRST = 1'b1; iFrame_Tick = 1'b0; iBall_Y = 10'd100; iBall_VY_Down = 1'b0;
      iServe = 1'b0; iGameOver = 1'b0; iRestart = 1'b0;

      // Reset values
      applyStimulus();
      applyStimulus();
      checkOutput("rst_state", oState, S_SERVE);
      checkOutput("rst_hold", oBall_Hold, 1);
      checkOutput("rst_hit", oBottom_Hit, 0);
      checkOutput("rst_respawn", oRespawn, 0);
      iRST = 1'b0;
      applyStimulus();

      // 1. Serve pulse of 5 cycles; PLAY after the third edge
      iServe = 1'b1;
      applyStimulus();
      checkOutput("serve_e1", oState, S_SERVE);
      applyStimulus();
      checkOutput("serve_e2", oState, S_SERVE);
      checkOutput("serve_e2_hold", oBall_Hold, 1);
      applyStimulus();
      checkOutput("serve_e3", oState, S_PLAY);
      checkOutput("serve_e3_hold", oBall_Hold, 0);
      applyStimulus();
      applyStimulus();
      iServe = 1'b0;

      // 2/3. Near misses: 471+8=479 is not a loss; moving up is not a loss
      iBall_Y = 10'd471; iBall_VY_Down = 1'b1; iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("y471_state", oState, S_PLAY);
      checkOutput("y471_hit", oBottom_Hit, 0);
      iBall_Y = 10'd475; iBall_VY_Down = 1'b0; iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("up_state", oState, S_PLAY);
      checkOutput("up_hit", oBottom_Hit, 0);
      // A loss-position ball with no frame tick must not trigger
      iBall_Y = 10'd472; iBall_VY_Down = 1'b1;
      applyStimulus();
      checkOutput("notick_state", oState, S_PLAY);

      // Real loss: one-cycle hit pulse
      iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("loss_state", oState, S_LOST);
      checkOutput("loss_hit", oBottom_Hit, 1);
      checkOutput("loss_hold", oBall_Hold, 1);
      applyStimulus();
      checkOutput("wait_state", oState, S_WAIT);
      checkOutput("wait_hit", oBottom_Hit, 0);

      // 4. 60 frame ticks; held serve must not serve
      frameTicks(57);
      iServe = 1'b1;
      frameTicks(2);
      checkOutput("t59_state", oState, S_WAIT);
      checkOutput("t59_respawn", oRespawn, 0);
      checkOutput("t59_hold", oBall_Hold, 1);
      iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("t60_state", oState, S_SERVE);
      checkOutput("t60_respawn", oRespawn, 1);
      checkOutput("t60_hold", oBall_Hold, 1);
      applyStimulus();
      checkOutput("t60_respawn_end", oRespawn, 0);
      repeat (5) applyStimulus();
      checkOutput("held_serve", oState, S_SERVE);
      iServe = 1'b0;
      repeat (3) applyStimulus();
      pressServe();
      checkOutput("repress_state", oState, S_PLAY);
      repeat (3) applyStimulus();

      // 5. Game over at the end of WAIT, serve ignored, restart recovers
      loseBall();
      checkOutput("go_wait", oState, S_WAIT);
      iGameOver = 1'b1;
      frameTicks(59);
      iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("go_state", oState, S_GAMEOVER);
      checkOutput("go_respawn", oRespawn, 1);
      iServe = 1'b1;
      repeat (5) applyStimulus();
      iServe = 1'b0;
      checkOutput("go_serve_ignored", oState, S_GAMEOVER);
      checkOutput("go_hold", oBall_Hold, 1);
      iRestart = 1'b1;
      applyStimulus();
      checkOutput("restart_state", oState, S_SERVE);
      checkOutput("restart_respawn", oRespawn, 1);
      applyStimulus();
      checkOutput("restart_held_respawn", oRespawn, 0);
      checkOutput("restart_held_state", oState, S_SERVE);
      iRestart = 1'b0; iGameOver = 1'b0;
      repeat (3) applyStimulus();

      // 6. Restart coinciding with a qualifying tick
      pressServe();
      checkOutput("pre_race_state", oState, S_PLAY);
      iBall_Y = 10'd472; iBall_VY_Down = 1'b1; iFrame_Tick = 1'b1; iRestart = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0; iRestart = 1'b0;
      checkOutput("race_state", oState, S_SERVE);
      checkOutput("race_hit", oBottom_Hit, 0);
      checkOutput("race_respawn", oRespawn, 1);
      applyStimulus();
      checkOutput("race_hit_after", oBottom_Hit, 0);
      repeat (3) applyStimulus();

      // Asynchronous reset in the middle of WAIT
      pressServe();
      loseBall();
      frameTicks(10);
      checkOutput("mid_wait", oState, S_WAIT);
      @(negedge iCLK);
      iRST = 1'b1;
      #1;
      checkOutput("arst_state", oState, S_SERVE);
      checkOutput("arst_hold", oBall_Hold, 1);
      checkOutput("arst_respawn", oRespawn, 0);
      checkOutput("arst_hit", oBottom_Hit, 0);
      applyStimulus();
      iRST = 1'b0;
      applyStimulus();

      // After reset, a full 60-tick wait is needed again: the count was cleared
      pressServe();
      loseBall();
      frameTicks(59);
      checkOutput("post_rst_t59", oState, S_WAIT);
      iFrame_Tick = 1'b1;
      applyStimulus();
      iFrame_Tick = 1'b0;
      checkOutput("post_rst_t60", oState, S_SERVE);
      checkOutput("post_rst_respawn", oRespawn, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
